// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants for the multiply/divide unit.
//   - op codes presented on mdu.op
//   - FSM state encoding (also visible on mdu.o_dbg_state)
//   - iteration count and counter width of the restoring divider
package mdu_pkg;

    // Operation codes; code 7 is unused and behaves as OP_NONE.
    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    // FSM state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // One quotient bit per cycle.
    localparam int DIV_ITER  = 32;
    localparam int DIV_CNT_W = $clog2(DIV_ITER);

endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: radix-2 restoring divider on 32-bit magnitudes.
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   i_load         capture dividend/divisor, clear remainder and counter
//   i_step         perform one quotient-bit iteration
//   i_dividend     dividend magnitude
//   i_divisor      divisor magnitude
//   o_quotient     quotient after the current step is applied
//   o_remainder    remainder after the current step is applied
//   o_last         current step is the final (DIV_ITER-th) iteration
// The outputs are the combinational result of the step in progress, so the
// caller can commit the final result on the same edge as the last step.
// A zero divisor simply yields quotient=all-ones, remainder=dividend; the
// caller applies its own override for that case.
module mdu_div_core
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder,
    output logic        o_last
);

    logic [31:0]          r_quot;   // dividend bits shift out, quotient bits shift in
    logic [31:0]          r_rem;
    logic [31:0]          r_div;
    logic [DIV_CNT_W-1:0] r_cnt;

    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;

    // Partial remainder is always below the divisor, so the shifted value
    // fits in 33 bits and the restored remainder fits back in 32.
    assign w_shift = {r_rem, r_quot[31]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    assign w_diff  = w_shift - {1'b0, r_div};

    assign o_quotient  = {r_quot[30:0], w_ge};
    assign o_remainder = w_ge ? w_diff[31:0] : w_shift[31:0];
    assign o_last      = (r_cnt == DIV_CNT_W'(DIV_ITER - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_quot <= i_dividend;
            r_rem  <= '0;
            r_div  <= i_divisor;
            r_cnt  <= '0;
        end else if (i_step) begin
            r_quot <= o_quotient;
            r_rem  <= o_remainder;
            r_cnt  <= r_cnt + DIV_CNT_W'(1);
        end
    end

endmodule

// File: rtl/mdu.sv
// mdu: multiply/divide unit with HI/LO registers for the EX stage.
// Ports:
//   clk          clock
//   rst          synchronous active-low reset
//   op[2:0]      operation code (see mdu_pkg)
//   start        an MDU instruction sits in EX (held while it stays there)
//   a, b         rs / rt operands
//   flush        cancel: aborts in-flight work, blocks acceptance
//   HI, LO       registered result registers
//   ALU_stall    hold F/D/E request to the hazard unit
//   ALU_done     one-cycle completion pulse (high exactly in DONE)
//   o_dbg_state  current FSM state
//
// Handshake: start acts as "valid" and !ALU_stall || ALU_done as "ready".
// A MULT/DIV is accepted on the edge where IDLE && start && !flush; from
// that cycle ALU_stall holds the pipeline until the DONE cycle, where
// ALU_done releases it so the same instruction leaves EX on that edge.
// start seen in MUL/DIV/DONE belongs to the already-accepted instruction
// and is ignored. MTHI/MTLO complete on the accepting edge without a stall.
module mdu
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  op,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        ALU_stall,
    output logic        ALU_done,
    output logic [1:0]  o_dbg_state
);

    logic [1:0]  r_state;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_signed;

    logic        w_is_mul;
    logic        w_is_div;
    logic        w_accept;
    logic        w_div_load;
    logic        w_div_step;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_core_q;
    logic [31:0] w_core_r;
    logic        w_div_last;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign w_is_div = (op == OP_DIV)  || (op == OP_DIVU);
    assign w_accept = (r_state == ST_IDLE) && start && !flush;

    // Only the signed divide takes magnitudes; DIVU passes raw operands.
    assign w_abs_a = ((op == OP_DIV) && a[31]) ? (~a + 32'd1) : a;
    assign w_abs_b = ((op == OP_DIV) && b[31]) ? (~b + 32'd1) : b;

    assign w_div_load = rst && w_accept && w_is_div;
    assign w_div_step = rst && (r_state == ST_DIV) && !flush;

    mdu_div_core u_div_core (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_div_load),
        .i_step      (w_div_step),
        .i_dividend  (w_abs_a),
        .i_divisor   (w_abs_b),
        .o_quotient  (w_core_q),
        .o_remainder (w_core_r),
        .o_last      (w_div_last)
    );

    // Extending to 64 bits first makes one 64x64 multiply (low half kept)
    // serve both the signed and unsigned product.
    assign w_ext_a = r_signed ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
    assign w_ext_b = r_signed ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
    assign w_prod  = w_ext_a * w_ext_b;

    // Quotient negative when signs differ; remainder follows the dividend.
    // 0x80000000 / -1 wraps back to 0x80000000 naturally.
    assign w_quot = (r_signed && (r_a[31] ^ r_b[31])) ? (~w_core_q + 32'd1) : w_core_q;
    assign w_rem  = (r_signed && r_a[31])             ? (~w_core_r + 32'd1) : w_core_r;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_hi     <= '0;
            r_lo     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        if (w_is_mul || w_is_div) begin
                            r_a      <= a;
                            r_b      <= b;
                            r_signed <= (op == OP_MULT) || (op == OP_DIV);
                            r_state  <= w_is_mul ? ST_MUL : ST_DIV;
                        end else if (op == OP_MTHI) begin
                            r_hi <= a;
                        end else if (op == OP_MTLO) begin
                            r_lo <= a;
                        end
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else begin
                        {r_hi, r_lo} <= w_prod;
                        r_state      <= ST_DONE;
                    end
                end
                ST_DIV: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else if (w_div_last) begin
                        if (r_b == 32'd0) begin
                            r_lo <= 32'hFFFF_FFFF;
                            r_hi <= r_a;
                        end else begin
                            r_lo <= w_quot;
                            r_hi <= w_rem;
                        end
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    // DONE: result already committed; flush or not, return.
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Gated by rst so both requests are quiet while reset is asserted,
    // even in the cycle before the synchronous reset takes effect.
    assign ALU_stall = rst && ((w_accept && (w_is_mul || w_is_div)) ||
                               (r_state != ST_IDLE));
    assign ALU_done  = rst && (r_state == ST_DONE);

    assign HI          = r_hi;
    assign LO          = r_lo;
    assign o_dbg_state = r_state;

endmodule
